// File: rtl/cpu_defs.sv
// Shared CPU definitions: divider state encoding, default datapath width and
// the fixed divide latency seen by the pipeline stall logic.
package cpu_defs;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_e;

  localparam int DIV_DATA_W = 32;
  localparam int DIV_LAT    = DIV_DATA_W + 2;

endpackage

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU; remainder goes to HI and the
// quotient to LO, with a fixed DATA_W+2 cycle latency from acceptance to done.
//
// state  | meaning
// IDLE   | waiting for div_start; operands latched on acceptance
// CALC   | one shift-subtract quotient bit per cycle, MSB first
// FIX    | sign correction / divide-by-zero result, outputs registered
// DONE   | div_done pulse, results valid
module div_unit
  import cpu_defs::*;
#(
  parameter int DATA_W = DIV_DATA_W,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              div_start,
  input  logic              div_signed,
  input  logic [DATA_W-1:0] div_src1,
  input  logic [DATA_W-1:0] div_src2,
  output logic              div_busy,
  output logic              div_done,
  output logic [DATA_W-1:0] div_hi,
  output logic [DATA_W-1:0] div_lo,
  output logic              div_by_zero
);

  div_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] src1_q;
  logic [DATA_W-1:0] dvs_q;
  logic [DATA_W-1:0] quo_q;
  logic [DATA_W:0]   rem_q;
  logic              neg1_q;
  logic              neg2_q;
  logic              busy_q;
  logic              done_q;
  logic              dbz_q;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;

  logic              src1_neg;
  logic              src2_neg;
  logic [DATA_W-1:0] src1_mag;
  logic [DATA_W-1:0] src2_mag;
  logic [DATA_W:0]   shift_rem;
  logic [DATA_W+1:0] trial;
  logic [DATA_W:0]   rem_d;
  logic [DATA_W-1:0] quo_d;
  logic [DATA_W-1:0] quo_fix;
  logic [DATA_W-1:0] rem_fix;

  always_comb begin
    src1_neg  = div_signed & div_src1[DATA_W-1];
    src2_neg  = div_signed & div_src2[DATA_W-1];
    // The most negative value negates to itself, which is its correct magnitude.
    src1_mag  = src1_neg ? (~div_src1 + DATA_W'(1)) : div_src1;
    src2_mag  = src2_neg ? (~div_src2 + DATA_W'(1)) : div_src2;

    shift_rem = {rem_q[DATA_W-1:0], quo_q[DATA_W-1]};
    trial     = {1'b0, shift_rem} - {2'b00, dvs_q};
    if (trial[DATA_W+1]) begin
      rem_d = shift_rem;
      quo_d = {quo_q[DATA_W-2:0], 1'b0};
    end else begin
      rem_d = trial[DATA_W:0];
      quo_d = {quo_q[DATA_W-2:0], 1'b1};
    end

    quo_fix = (neg1_q ^ neg2_q) ? (~quo_q + DATA_W'(1)) : quo_q;
    rem_fix = neg1_q ? (~rem_q[DATA_W-1:0] + DATA_W'(1)) : rem_q[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      src1_q  <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      neg1_q  <= 1'b0;
      neg2_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (div_start) begin
            src1_q  <= div_src1;
            dvs_q   <= src2_mag;
            quo_q   <= src1_mag;
            rem_q   <= '0;
            neg1_q  <= src1_neg;
            neg2_q  <= src2_neg;
            cnt_q   <= CNT_W'(DATA_W - 1);
            busy_q  <= 1'b1;
            state_q <= S_CALC;
          end
        end
        S_CALC: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          if (cnt_q == '0) begin
            state_q <= S_FIX;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_FIX: begin
          // A zero divisor reports the raw dividend rather than a corrected remainder.
          if (dvs_q == '0) begin
            hi_q  <= src1_q;
            lo_q  <= '1;
            dbz_q <= 1'b1;
          end else begin
            hi_q  <= rem_fix;
            lo_q  <= quo_fix;
            dbz_q <= 1'b0;
          end
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign div_busy    = busy_q;
  assign div_done    = done_q;
  assign div_hi      = hi_q;
  assign div_lo      = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases, reset abort and
// random DIV/DIVU operations compared against an arithmetic reference.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        div_start = 1'b0;
  logic        div_signed = 1'b0;
  logic [31:0] div_src1 = '0;
  logic [31:0] div_src2 = '0;
  logic        div_busy;
  logic        div_done;
  logic [31:0] div_hi;
  logic [31:0] div_lo;
  logic        div_by_zero;

  int n_chk  = 0;
  int n_fail = 0;

  div_unit #(.DATA_W(32), .CNT_W(5)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .div_start   (div_start),
    .div_signed  (div_signed),
    .div_src1    (div_src1),
    .div_src2    (div_src2),
    .div_busy    (div_busy),
    .div_done    (div_done),
    .div_hi      (div_hi),
    .div_lo      (div_lo),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: truncating division with remainder signed like the dividend;
  // 64-bit arithmetic keeps -2^31 / -1 from overflowing before truncation.
  function automatic void model(input logic sg, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo, output logic dz);
    longint sa, sb, q, r;
    if (b == 32'd0) begin
      hi = a;
      lo = 32'hFFFF_FFFF;
      dz = 1'b1;
    end else if (sg) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      lo = q[31:0];
      hi = r[31:0];
      dz = 1'b0;
    end else begin
      lo = a / b;
      hi = a % b;
      dz = 1'b0;
    end
  endfunction

  // Called at a falling edge with the unit idle. Sample c counts falling edges
  // after the accepting rising edge; done must appear at c=34, busy for c=1..34.
  // inj_at drives a competing start with other operands in that cycle.
  task automatic do_div(input string tag, input logic sg, input logic [31:0] a,
                        input logic [31:0] b, input int inj_at,
                        input logic [31:0] a2, input logic [31:0] b2);
    logic [31:0] ehi, elo;
    logic        edz;
    int          lat, dcnt, bcnt;
    model(sg, a, b, ehi, elo, edz);
    div_start  = 1'b1;
    div_signed = sg;
    div_src1   = a;
    div_src2   = b;
    @(negedge clk);
    div_start = 1'b0;
    lat  = 0;
    dcnt = 0;
    bcnt = 0;
    for (int c = 1; c <= 40; c++) begin
      if (div_busy) bcnt++;
      if (div_done) begin
        dcnt++;
        lat = c;
      end
      if (c == inj_at) begin
        div_start  = 1'b1;
        div_signed = ~sg;
        div_src1   = a2;
        div_src2   = b2;
      end else begin
        div_start = 1'b0;
      end
      @(negedge clk);
    end
    chk({tag, ".latency"}, 32'(lat), 32'd34);
    chk({tag, ".done_pulses"}, 32'(dcnt), 32'd1);
    chk({tag, ".busy_cycles"}, 32'(bcnt), 32'd34);
    chk({tag, ".hi"}, div_hi, ehi);
    chk({tag, ".lo"}, div_lo, elo);
    chk({tag, ".by_zero"}, {31'd0, div_by_zero}, {31'd0, edz});
  endtask

  initial begin
    logic        sg;
    logic [31:0] a, b;
    int          sel;

    repeat (3) @(negedge clk);
    chk("rst.busy", {31'd0, div_busy}, 32'd0);
    chk("rst.done", {31'd0, div_done}, 32'd0);
    chk("rst.hi", div_hi, 32'd0);
    chk("rst.lo", div_lo, 32'd0);
    chk("rst.by_zero", {31'd0, div_by_zero}, 32'd0);
    resetn = 1'b1;

    do_div("u100_7", 1'b0, 32'd100, 32'd7, 0, '0, '0);
    do_div("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 0, '0, '0);
    do_div("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 0, '0, '0);
    do_div("s_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, '0, '0);
    do_div("u_by_zero", 1'b0, 32'h1234_5678, 32'd0, 0, '0, '0);
    do_div("s_by_zero", 1'b1, 32'h8765_4321, 32'd0, 0, '0, '0);
    do_div("start_busy", 1'b0, 32'hDEAD_BEEF, 32'd13, 10, 32'd55, 32'd5);
    do_div("start_done", 1'b1, 32'hFFFF_FF00, 32'd3, 34, 32'd99, 32'd9);

    // Abort mid-CALC: outputs clear on the next cycle, then restart immediately.
    div_start  = 1'b1;
    div_signed = 1'b0;
    div_src1   = 32'hCAFE_F00D;
    div_src2   = 32'd3;
    @(negedge clk);
    div_start = 1'b0;
    repeat (14) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    chk("abort.busy", {31'd0, div_busy}, 32'd0);
    chk("abort.done", {31'd0, div_done}, 32'd0);
    chk("abort.hi", div_hi, 32'd0);
    chk("abort.lo", div_lo, 32'd0);
    chk("abort.by_zero", {31'd0, div_by_zero}, 32'd0);
    resetn = 1'b1;
    do_div("post_reset", 1'b1, 32'hFFFF_FC18, 32'd7, 0, '0, '0);

    for (int i = 0; i < 20; i++) begin
      sg  = 1'($urandom_range(0, 1));
      a   = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      sel = $urandom_range(0, 7);
      case (sel)
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 15));
        3:       b = 32'h8000_0000;
        default: b = $urandom;
      endcase
      do_div($sformatf("rand%0d", i), sg, a, b, 0, '0, '0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the operand and result width.
REQ-002 The block SHALL have parameter CNT_W, default 5, giving the iteration counter width (log2 DATA_W).
REQ-003 The block SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-004 The block SHALL have port resetn, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port div_start, input, 1 bit: request a divide; sampled only in IDLE.
REQ-006 The block SHALL have port div_signed, input, 1 bit: 1 = signed (DIV), 0 = unsigned (DIVU); sampled with div_start.
REQ-007 The block SHALL have port div_src1, input, DATA_W bits: dividend (rs value).
REQ-008 The block SHALL have port div_src2, input, DATA_W bits: divisor (rt value).
REQ-009 The block SHALL have port div_busy, output, 1 bit: high from the cycle after acceptance through the DONE cycle.
REQ-010 The block SHALL have port div_done, output, 1 bit: one-cycle pulse when results are valid.
REQ-011 The block SHALL have port div_hi, output, DATA_W bits: remainder, destined for HI.
REQ-012 The block SHALL have port div_lo, output, DATA_W bits: quotient, destined for LO.
REQ-013 The block SHALL have port div_by_zero, output, 1 bit: divisor was zero; valid with div_done.

Function
REQ-014 The block SHALL implement FSM states IDLE, CALC, FIX, DONE.
REQ-015 In IDLE with div_start=1, the block SHALL latch operands and div_signed, load the counter with DATA_W-1, and enter CALC.
REQ-016 On acceptance, the block SHALL convert signed operands to magnitudes: |src| as unsigned DATA_W; 0x80000000 maps to 0x80000000.
REQ-017 In CALC, the block SHALL perform one restoring shift-subtract step per cycle, producing one quotient bit, MSB first, with a DATA_W+1-bit partial remainder.
REQ-018 CALC SHALL last exactly DATA_W cycles; when the counter equals 0, the next state SHALL be FIX.
REQ-019 FIX SHALL last one cycle and perform sign correction: quotient negated if the operand signs differ (signed mode), remainder negated if the dividend is negative (signed mode), giving truncation toward zero with the remainder carrying the dividend's sign. Results SHALL be registered into div_hi and div_lo.
REQ-020 DONE SHALL last one cycle with div_done=1, then return to IDLE.
REQ-021 Latency SHALL be fixed: with start accepted at edge N, div_done=1 during cycle N+DATA_W+2 (34 for 32-bit).
REQ-022 div_hi, div_lo and div_by_zero SHALL hold their values from DONE until the next FIX.
REQ-023 div_start while busy SHALL be ignored, with no queuing and no effect on the running operation.
REQ-024 A divisor of 0 SHALL run with identical latency and produce div_lo = all ones, div_hi = raw div_src1 (no sign correction), and div_by_zero=1.
REQ-025 A signed 0x80000000 / 0xFFFFFFFF SHALL produce div_lo = 0x80000000 and div_hi = 0, with no flag.
REQ-026 A div_start asserted in the DONE cycle SHALL be ignored; the earliest acceptance is the following IDLE cycle.

Reset
REQ-027 When resetn=0 at a clock edge, the block SHALL enter IDLE and clear div_busy, div_done, div_by_zero, div_hi, div_lo, the counter and all operand registers to 0.
REQ-028 Reset asserted mid-CALC or mid-FIX SHALL abort the operation with no div_done pulse.
REQ-029 The first start SHALL be accepted in the first cycle after resetn returns high.

Structure
REQ-030 The FSM state encoding (2 bits), DATA_W default and latency constant DIV_LAT = DATA_W+2 SHALL reside in a shared cpu_defs package.
REQ-031 The block SHALL be a single module with no sub-modules; the negate/abs logic SHALL be inline.
REQ-032 The CPU SHALL stall PC update while div_busy=1 and write HI/LO on div_done.

Verification
REQ-033 Unsigned 100 / 7 -> div_lo=14, div_hi=2, div_done exactly 34 cycles after start.
REQ-034 Signed 0xFFFFFFF9 (-7) / 2 -> div_lo=0xFFFFFFFD, div_hi=0xFFFFFFFF; signed 7 / -2 -> div_lo=0xFFFFFFFD, div_hi=1.
REQ-035 Signed 0x80000000 / 0xFFFFFFFF -> div_lo=0x80000000, div_hi=0, div_by_zero=0.
REQ-036 Unsigned 0x12345678 / 0 -> div_lo=0xFFFFFFFF, div_hi=0x12345678, div_by_zero=1, latency 34.
REQ-037 Second div_start at cycle 10 of a running op with different operands -> first result unchanged, single done pulse, busy never drops early.
REQ-038 resetn=0 at CALC cycle 15 -> next cycle busy=0, done=0, hi=lo=0; a new start after reset completes correctly in 34 cycles.
